// File: rtl/riscv_pkg.sv
// Shared RV32 privilege/status types, CSR addresses and field masks.
// Define RISCV_SMODE_EN to build with supervisor mode and the sstatus view.
package riscv_pkg;

`ifdef RISCV_SMODE_EN
    localparam bit SMODE_EN = 1'b1;
`else
    localparam bit SMODE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        XS_OFF     = 2'b00,
        XS_INITIAL = 2'b01,
        XS_CLEAN   = 2'b10,
        XS_DIRTY   = 2'b11
    } xs_t;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MSTATUSH = 12'h310;
    localparam logic [11:0] CSR_SSTATUS  = 12'h100;

    typedef struct packed {
        logic        sd;
        logic [10:0] wpri30;
        logic        mxr;
        logic        sum;
        logic        mprv;
        xs_t         xs;
        xs_t         fs;
        priv_lvl_t   mpp;
        logic [1:0]  vs;
        logic        spp;
        logic        mpie;
        logic        ube;
        logic        spie;
        logic        wpri4;
        logic        mie;
        logic        wpri2;
        logic        sie;
        logic        wpri0;
    } mstatus_rv32_t;

    localparam logic [31:0] SSTATUS_MASK = 32'h800D_E762;

    // Bits software may change; FS/VS/XS/UBE/SD stay hardwired to zero.
`ifdef RISCV_SMODE_EN
    localparam logic [31:0] MSTATUS_WMASK = 32'h000E_19AA;
`else
    localparam logic [31:0] MSTATUS_WMASK = 32'h0002_1888;
`endif

endpackage

// File: rtl/status_wmask.sv
// Next mstatus value for a CSR op: view/writable masking plus MPP WARL.
// MPP legality depends on RISCV_SMODE_EN (via riscv_pkg::SMODE_EN).
module status_wmask
    import riscv_pkg::*;
(
    input  logic [31:0] old_val,
    input  logic [31:0] operand,
    input  csr_op_e     op,
    input  logic        sview,
    output logic [31:0] new_val
);

    logic [31:0] raw;
    logic [31:0] mask;
    logic [31:0] merged;
    logic [1:0]  mpp_new;
    logic        mpp_bad;

    always_comb begin
        raw = old_val;
        unique case (op)
            CSR_READ:  raw = old_val;
            CSR_WRITE: raw = operand;
            CSR_SET:   raw = old_val | operand;
            CSR_CLEAR: raw = old_val & ~operand;
        endcase
    end

    assign mask    = (sview ? SSTATUS_MASK : 32'hFFFF_FFFF) & MSTATUS_WMASK;
    assign merged  = (old_val & ~mask) | (raw & mask);
    assign mpp_new = merged[12:11];
    assign mpp_bad = (mpp_new == 2'b10) || (!SMODE_EN && mpp_new == 2'b01);

    always_comb begin
        new_val = merged;
        if (mpp_bad) new_val[12:11] = old_val[12:11];
    end

endmodule

// File: rtl/status_csr_unit.sv
// mstatus/sstatus owner and privilege tracker with trap/return updates.
// Supervisor features are enabled by defining RISCV_SMODE_EN.
module status_csr_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            csr_req_valid_i,
    output logic            csr_req_ready_o,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_rsp_valid_o,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_rsp_err_o,
    input  logic            trap_i,
    input  logic            trap_to_s_i,
    input  logic            mret_i,
    input  logic            sret_i,
    output logic [1:0]      priv_lvl_o,
    output logic [XLEN-1:0] mstatus_o
);

    mstatus_rv32_t mst_q, mst_d;
    priv_lvl_t     priv_q, priv_d;

    logic        is_m, is_mh, is_s;
    logic        accept, err_d, req_wr;
    logic        trap_s, sret_ok;
    logic [31:0] rdata_d;
    logic [31:0] new_val;
    csr_op_e     op;

    assign op    = csr_op_e'(csr_op_i);
    assign is_m  = csr_addr_i == CSR_MSTATUS;
    assign is_mh = csr_addr_i == CSR_MSTATUSH;
    assign is_s  = csr_addr_i == CSR_SSTATUS;

    assign csr_req_ready_o = !(trap_i || mret_i || (SMODE_EN && sret_i));
    assign accept          = csr_req_valid_i && csr_req_ready_o;

    assign err_d = !(is_m || is_mh || is_s)
                || priv_q == PRIV_U
                || ((is_m || is_mh) && priv_q == PRIV_S)
                || (is_s && !SMODE_EN);

    assign req_wr = accept && !err_d && !is_mh && op != CSR_READ;

    // A trap taken in M never drops to S, even if delegation is requested.
    assign trap_s  = SMODE_EN && trap_to_s_i && priv_q != PRIV_M;
    assign sret_ok = SMODE_EN && sret_i && priv_q != PRIV_U;

    always_comb begin
        rdata_d = 32'h0;
        if (!err_d) begin
            unique case (1'b1)
                is_m:    rdata_d = mst_q;
                is_s:    rdata_d = mst_q & SSTATUS_MASK;
                default: rdata_d = 32'h0;
            endcase
        end
    end

    status_wmask u_wmask (
        .old_val (mst_q),
        .operand (csr_wdata_i),
        .op      (op),
        .sview   (is_s),
        .new_val (new_val)
    );

    always_comb begin
        mst_d  = mst_q;
        priv_d = priv_q;
        if (trap_i) begin
            if (trap_s) begin
                mst_d.spie = mst_q.sie;
                mst_d.sie  = 1'b0;
                mst_d.spp  = priv_q[0];
                priv_d     = PRIV_S;
            end else begin
                mst_d.mpie = mst_q.mie;
                mst_d.mie  = 1'b0;
                mst_d.mpp  = priv_q;
                priv_d     = PRIV_M;
            end
        end else if (mret_i) begin
            mst_d.mie  = mst_q.mpie;
            mst_d.mpie = 1'b1;
            mst_d.mpp  = PRIV_U;
            priv_d     = mst_q.mpp;
            if (mst_q.mpp != PRIV_M) mst_d.mprv = 1'b0;
        end else if (sret_ok) begin
            mst_d.sie  = mst_q.spie;
            mst_d.spie = 1'b1;
            mst_d.spp  = 1'b0;
            mst_d.mprv = 1'b0;
            priv_d     = priv_lvl_t'({1'b0, mst_q.spp});
        end else if (req_wr) begin
            mst_d = mstatus_rv32_t'(new_val);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_q           <= '0;
            priv_q          <= PRIV_M;
            csr_rsp_valid_o <= 1'b0;
            csr_rdata_o     <= '0;
            csr_rsp_err_o   <= 1'b0;
        end else begin
            mst_q           <= mst_d;
            priv_q          <= priv_d;
            csr_rsp_valid_o <= accept;
            if (accept) begin
                csr_rdata_o   <= rdata_d;
                csr_rsp_err_o <= err_d;
            end
        end
    end

    assign priv_lvl_o = priv_q;
    assign mstatus_o  = mst_q;

endmodule

// File: tb/tb_status_csr_unit.sv
// Scoreboard bench for status_csr_unit; follows RISCV_SMODE_EN if defined.
// Responses are checked by a negedge monitor against queued expectations.
module tb_status_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        trap, trap_to_s, mret, sret;
    logic [1:0]  priv;
    logic [31:0] mstatus;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    status_csr_unit #(.XLEN(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .csr_req_valid_i (req_valid),
        .csr_req_ready_o (req_ready),
        .csr_addr_i      (addr),
        .csr_op_i        (op),
        .csr_wdata_i     (wdata),
        .csr_rsp_valid_o (rsp_valid),
        .csr_rdata_o     (rdata),
        .csr_rsp_err_o   (rsp_err),
        .trap_i          (trap),
        .trap_to_s_i     (trap_to_s),
        .mret_i          (mret),
        .sret_i          (sret),
        .priv_lvl_o      (priv),
        .mstatus_o       (mstatus)
    );

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected rdata=%h err=%b", rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if ({rdata, rsp_err} !== {e.rdata, e.err}) begin
                    bad++;
                    $display("FAIL rsp got rdata=%h err=%b exp rdata=%h err=%b",
                             rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [1:0] o,
                         input logic [31:0] wd, input logic [31:0] er,
                         input logic ee);
        req_valid = 1'b1;
        addr      = a;
        op        = o;
        wdata     = wd;
        sb.push_back('{rdata: er, err: ee});
    endtask

    task automatic idle;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++;
        if ({priv, mstatus} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL reset_state priv=%b mst=%h exp 11/0", priv, mstatus);
        end
        total++;
        if ({req_ready, rsp_valid, rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_rsp rdy=%b v=%b rd=%h err=%b",
                     req_ready, rsp_valid, rdata, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(12'h300, 2'b00, 32'h0, 32'h0, 1'b0);
        step();
        idle();
    endtask

    task automatic test_write_read;
        drive(12'h300, 2'b01, 32'h0000_1888, 32'h0, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== 32'h0000_1888) begin
            bad++;
            $display("FAIL write_visible got=%h exp=%h", mstatus, 32'h1888);
        end
        drive(12'h300, 2'b00, 32'h0, 32'h0000_1888, 1'b0);
        step();
        idle();
    endtask

    task automatic test_set_clear;
        drive(12'h300, 2'b11, 32'h0000_1800, 32'h0000_1888, 1'b0);
        step();
        drive(12'h300, 2'b10, 32'h0000_1000, 32'h0000_0088, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== 32'h0000_0088) begin
            bad++;
            $display("FAIL set_mpp10 got=%h exp=%h", mstatus, 32'h88);
        end
        drive(12'h300, 2'b10, 32'h0000_1800, 32'h0000_0088, 1'b0);
        step();
        idle();
    endtask

    task automatic test_mpp_warl;
        logic [31:0] x;
        drive(12'h300, 2'b01, 32'h0000_1000, 32'h0000_1888, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== 32'h0000_1800) begin
            bad++;
            $display("FAIL mpp_10 got=%h exp=%h", mstatus, 32'h1800);
        end
`ifdef RISCV_SMODE_EN
        x = 32'h0000_0800;
`else
        x = 32'h0000_1800;
`endif
        drive(12'h300, 2'b01, 32'h0000_0800, 32'h0000_1800, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== x) begin
            bad++;
            $display("FAIL mpp_01 got=%h exp=%h", mstatus, x);
        end
    endtask

    task automatic test_masks;
        logic [31:0] prev, wm, sv;
        logic        serr;
`ifdef RISCV_SMODE_EN
        prev = 32'h0000_0800;
        wm   = 32'h000E_19AA;
        sv   = 32'h000C_0122;
        serr = 1'b0;
`else
        prev = 32'h0000_1800;
        wm   = 32'h0002_1888;
        sv   = 32'h0;
        serr = 1'b1;
`endif
        drive(12'h300, 2'b01, 32'hFFFF_FFFF, prev, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== wm) begin
            bad++;
            $display("FAIL write_ones got=%h exp=%h", mstatus, wm);
        end
        drive(12'h310, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0);
        step();
        drive(12'h301, 2'b00, 32'h0, 32'h0, 1'b1);
        step();
        drive(12'h100, 2'b00, 32'h0, sv, serr);
        step();
        drive(12'h100, 2'b01, 32'h0, sv, serr);
        step();
        idle();
        total++;
        if (mstatus !== 32'h0002_1888) begin
            bad++;
            $display("FAIL sstatus_write got=%h exp=%h", mstatus, 32'h21888);
        end
    endtask

    task automatic test_back_to_back;
        drive(12'h300, 2'b01, 32'h0000_0088, 32'h0002_1888, 1'b0);
        step();
        drive(12'h300, 2'b00, 32'h0, 32'h0000_0088, 1'b0);
        step();
        drive(12'h300, 2'b11, 32'h0000_0008, 32'h0000_0088, 1'b0);
        step();
        drive(12'h300, 2'b00, 32'h0, 32'h0000_0080, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== 32'h0000_0080) begin
            bad++;
            $display("FAIL b2b_final got=%h exp=%h", mstatus, 32'h80);
        end
    endtask

    task automatic test_mret_trap;
        drive(12'h300, 2'b01, 32'h0000_0088, 32'h0000_0080, 1'b0);
        step();
        idle();
        mret = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL mret_ready got=%b exp=0", req_ready);
        end
        step();
        mret = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b00, 32'h0000_0088}) begin
            bad++;
            $display("FAIL mret priv=%b mst=%h exp 00/88", priv, mstatus);
        end
        drive(12'h300, 2'b01, 32'h0, 32'h0, 1'b1);
        step();
        idle();
        sret = 1'b1;
        step();
        sret = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b00, 32'h0000_0088}) begin
            bad++;
            $display("FAIL u_no_change priv=%b mst=%h exp 00/88", priv, mstatus);
        end
        trap = 1'b1;
        step();
        trap = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b11, 32'h0000_0080}) begin
            bad++;
            $display("FAIL trap_m priv=%b mst=%h exp 11/80", priv, mstatus);
        end
    endtask

    task automatic test_mprv;
        drive(12'h300, 2'b01, 32'h0002_1800, 32'h0000_0080, 1'b0);
        step();
        idle();
        mret = 1'b1;
        step();
        total++;
        if ({priv, mstatus} !== {2'b11, 32'h0002_0080}) begin
            bad++;
            $display("FAIL mret_keep_mprv priv=%b mst=%h exp 11/20080", priv, mstatus);
        end
        step();
        mret = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b00, 32'h0000_0088}) begin
            bad++;
            $display("FAIL mret_clr_mprv priv=%b mst=%h exp 00/88", priv, mstatus);
        end
        trap = 1'b1;
        step();
        trap = 1'b0;
    endtask

    task automatic test_trap_stall;
        drive(12'h300, 2'b01, 32'h0000_1888, 32'h0000_0080, 1'b0);
        step();
        drive(12'h300, 2'b01, 32'h0000_0008, 32'h0000_1880, 1'b0);
        trap = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready got=%b exp=0", req_ready);
        end
        step();
        trap = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b11, 32'h0000_1880}) begin
            bad++;
            $display("FAIL stall_trap priv=%b mst=%h exp 11/1880", priv, mstatus);
        end
        step();
        idle();
        total++;
        if (mstatus !== 32'h0000_0008) begin
            bad++;
            $display("FAIL stall_write got=%h exp=%h", mstatus, 32'h8);
        end
    endtask

`ifdef RISCV_SMODE_EN
    task automatic test_smode;
        drive(12'h300, 2'b01, 32'h0000_0800, 32'h0000_0008, 1'b0);
        step();
        idle();
        mret = 1'b1;
        step();
        mret = 1'b0;
        drive(12'h300, 2'b00, 32'h0, 32'h0, 1'b1);
        step();
        idle();
        total++;
        if ({priv, mstatus} !== {2'b01, 32'h0000_0080}) begin
            bad++;
            $display("FAIL s_entry priv=%b mst=%h exp 01/80", priv, mstatus);
        end
        drive(12'h100, 2'b10, 32'h0000_0002, 32'h0, 1'b0);
        step();
        idle();
        total++;
        if (mstatus !== 32'h0000_0082) begin
            bad++;
            $display("FAIL s_set_sie got=%h exp=%h", mstatus, 32'h82);
        end
        trap = 1'b1;
        trap_to_s = 1'b1;
        step();
        trap = 1'b0;
        trap_to_s = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b01, 32'h0000_01A0}) begin
            bad++;
            $display("FAIL trap_s priv=%b mst=%h exp 01/1a0", priv, mstatus);
        end
        sret = 1'b1;
        step();
        sret = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b01, 32'h0000_00A2}) begin
            bad++;
            $display("FAIL sret priv=%b mst=%h exp 01/a2", priv, mstatus);
        end
        trap = 1'b1;
        step();
        trap = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b11, 32'h0000_0822}) begin
            bad++;
            $display("FAIL trap_s_to_m priv=%b mst=%h exp 11/822", priv, mstatus);
        end
    endtask
`else
    task automatic test_no_smode;
        mret = 1'b1;
        step();
        mret = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b00, 32'h0000_0080}) begin
            bad++;
            $display("FAIL ns_mret priv=%b mst=%h exp 00/80", priv, mstatus);
        end
        trap = 1'b1;
        trap_to_s = 1'b1;
        step();
        trap = 1'b0;
        trap_to_s = 1'b0;
        total++;
        if ({priv, mstatus} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL ns_trap_s priv=%b mst=%h exp 11/0", priv, mstatus);
        end
    endtask
`endif

    initial begin
        req_valid = 1'b0;
        addr      = 12'h0;
        op        = 2'b00;
        wdata     = 32'h0;
        trap      = 1'b0;
        trap_to_s = 1'b0;
        mret      = 1'b0;
        sret      = 1'b0;
        test_reset();
        test_write_read();
        test_set_clear();
        test_mpp_warl();
        test_masks();
        test_back_to_back();
        test_mret_trap();
        test_mprv();
        test_trap_stall();
`ifdef RISCV_SMODE_EN
        test_smode();
`else
        test_no_smode();
`endif
        repeat (3) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rsp_missing pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_csr_unit.md
# status_csr_unit

Owns the machine/supervisor status state for the RV32 core: the `mstatus` register, its restricted `sstatus` view, and the current privilege level. It serves CSR read/modify/write requests from the execute stage over a valid/ready handshake. It also applies the hardware-side updates on trap entry and on `mret`/`sret`. It sits beside the CSR file, and its privilege and status outputs feed the decoder, interrupt controller and MMU.

## Interface
Parameters:
- `XLEN`, 32, register width; only 32 is supported.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `csr_req_valid_i`  in  1  CSR request valid
- `csr_req_ready_o`  out  1  request accepted when valid&ready
- `csr_addr_i`  in  12  0x300 `mstatus`, 0x310 `mstatush`, 0x100 `sstatus`
- `csr_op_i`  in  2  00 read, 01 write, 10 set, 11 clear
- `csr_wdata_i`  in  32  write/set/clear operand
- `csr_rsp_valid_o`  out  1  one-cycle response pulse
- `csr_rdata_o`  out  32  pre-update register value
- `csr_rsp_err_o`  out  1  illegal access; no state change
- `trap_i`  in  1  trap taken this cycle
- `trap_to_s_i`  in  1  trap is delegated to S
- `mret_i`, `sret_i`  in  1 each  return instructions retiring
- `priv_lvl_o`  out  2  current privilege, `priv_lvl_t` encoding
- `mstatus_o`  out  32  live `mstatus` value

## Operation
- `mstatus` field bits: SIE[1], MIE[3], SPIE[5], UBE[6], MPIE[7], SPP[8], VS[10:9], MPP[12:11], FS[14:13], XS[16:15], MPRV[17], SUM[18], MXR[19], SD[31]. All other bits read 0 and ignore writes.
- FS, VS, XS, UBE and SD are hardwired to 0. `mstatush` reads 0 and ignores writes.
- `sstatus` view exposes only SIE, SPIE, UBE, SPP, VS, FS, XS, SUM, MXR and SD. Writes through it touch only those bits.
- New value: write gives wdata; set gives old|wdata; clear gives old&~wdata. Read (op 00) writes nothing.
- MPP is WARL: a written value of 2'b10 is dropped and MPP keeps its old value.
- `csr_rsp_err_o` is set for:
  - an unknown address;
  - any access while priv is U;
  - `mstatus`/`mstatush` access from S.
- Trap to M (`trap_i` with `trap_to_s_i`=0, or any trap while priv is M): MPIE←MIE, MIE←0, MPP←priv, priv←M.
- Trap to S: SPIE←SIE, SIE←0, SPP←priv[0], priv←S.
- `mret`: MIE←MPIE, MPIE←1, priv←MPP, MPP←U. If MPP≠M, MPRV←0.
- `sret`: SIE←SPIE, SPIE←1, priv←{0,SPP}, SPP←0, MPRV←0. `sret` is ignored while priv is U.
- Event priority in one cycle: trap > mret > sret > CSR request.

## Timing
- Reset values:
  - priv=M; all `mstatus` bits 0.
  - `csr_req_ready_o`=1; `csr_rsp_valid_o`=0, `csr_rdata_o`=0, `csr_rsp_err_o`=0.
- `csr_req_ready_o` is 0 in any cycle where `trap_i`, `mret_i` or `sret_i` is high. The request stalls and is not consumed.
- A request accepted in cycle N produces:
  - a response in cycle N+1, with `csr_rdata_o` holding the value before the write;
  - the register update visible on `mstatus_o` in cycle N+1.
- Back-to-back requests are accepted every cycle. The second request reads the first request's result.
- Trap and return updates take effect on `priv_lvl_o` and `mstatus_o` the cycle after the event.
- Response outputs other than the valid pulse hold their last value. There is no response backpressure.
- Reset asserted mid-operation clears everything immediately. A pending response is lost.

## Configuration
- `RISCV_SMODE_EN` defined: full behaviour as above.
- `RISCV_SMODE_EN` undefined:
  - `sstatus` access raises an error;
  - SIE, SPIE, SPP, SUM and MXR read 0 and ignore writes;
  - `trap_to_s_i` and `sret_i` are ignored;
  - MPP additionally drops writes of 2'b01, so only M and U are legal.

## Structure
- `riscv_pkg` holds:
  - the existing `priv_lvl_t` and `xs_t`;
  - CSR address constants `CSR_MSTATUS`, `CSR_MSTATUSH`, `CSR_SSTATUS`;
  - a new `mstatus_rv32_t` packed struct and `SSTATUS_MASK`;
  - a `csr_op_e` enum.
- One sub-module, `status_wmask`, is a natural split. It computes the WARL/masked next value from the old value, the operand, the op and the view.

## Test plan
- Reset, then read 0x300 from M: rdata=0x0, err=0, and `priv_lvl_o`=2'b11.
- From M, write 0x300 with 0x0000_1888, then read: the write returns 0x0; the read returns 0x0000_1888 (MIE, MPIE and MPP=M set).
- From M, write MPP=2'b10 (0x0000_1000) over MPP=M: MPP stays 2'b11. With `RISCV_SMODE_EN` undefined, writing 0x0000_0800 leaves MPP unchanged.
- From M with MIE=1, MPP=U, assert `mret_i`, then assert `trap_i`:
  - after `mret_i`: priv=U, MIE=1, MPIE=1;
  - after `trap_i`: priv=M, MPP=U, MIE=0, MPIE=1.
- In S, read 0x300: err=1 with no state change. Then set 0x100 with 0x0000_0002: SIE=1, and `mstatus_o` bit 3 is unchanged.
- Assert `trap_i` and a valid CSR write in the same cycle: ready=0, the trap applies, and the write completes one cycle later.
